pixel_fmt_conv: RTL and testbench

- Parametrised, pipelined RGB pixel format converter. Expands packed RGB input of configurable per-channel widths to wider output channels.
- Supports three fill modes: zero-pad, MSB-replicate, and greyscale.
- Sits on the video path between the RGB565 capture/DMA source and the RGB888 display/processing sinks.
- Uses a valid/ready stream handshake with frame/line sideband, so it can stall under back-pressure without losing pixels.

---
 rtl/pixel_fmt_conv.sv | 175 +++++++++++++++++
 tb/tb_pixel_fmt_conv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fmt_conv.sv
// rtl/pixel_fmt_conv.sv - two-stage pipelined packed-RGB to wide-RGB format converter
//
// Purpose:
//   Expands a packed {R,G,B} pixel (R in MSBs) to three CH_OUT_W-bit channels.
//   Fill modes: 00 zero-pad, 01/11 MSB-replicate, 10 greyscale {Y,Y,Y}.
//   Valid/ready stream on both sides with sof/eol sideband delayed alongside.
//
// Optional build macro:
//   PIXEL_FMT_CONV_STATS_EN - adds pix_cnt / frame_cnt output counters.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   input pixel stream, s_data = {R,G,B}
//   s_sof/s_eol              input sideband, travels with the pixel
//   mode                     fill mode, sampled per pixel on the input beat
//   m_valid/m_ready/m_data   output pixel stream, m_data = {R,G,B}
//   m_sof/m_eol              output sideband aligned with m_data
//   pix_cnt/frame_cnt        (stats build only) output beat / frame counters

module pixel_fmt_conv #(
  parameter int R_IN_W   = 5,
  parameter int G_IN_W   = 6,
  parameter int B_IN_W   = 5,
  parameter int CH_OUT_W = 8,
  localparam int IN_W    = R_IN_W + G_IN_W + B_IN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  input  logic [1:0]            mode,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [3*CH_OUT_W-1:0] m_data,
  output logic                  m_sof,
`ifdef PIXEL_FMT_CONV_STATS_EN
  output logic                  m_eol,
  output logic [31:0]           pix_cnt,
  output logic [15:0]           frame_cnt
`else
  output logic                  m_eol
`endif
);

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_GREY = 2'b10;

  // Expands the low w bits of v into CH_OUT_W bits, MSB-aligned. The fill
  // bits are either zero or the top bits of the channel repeated. Because
  // CH_OUT_W <= 2*w, a single repeat always suffices.
  function automatic logic [CH_OUT_W-1:0] expand(input logic [CH_OUT_W-1:0] v,
                                                 input int w,
                                                 input logic rep);
    logic [CH_OUT_W-1:0] o;
    o = '0;
    for (int i = 0; i < CH_OUT_W; i++) begin
      if (i < w)
        o[CH_OUT_W-1-i] = v[w-1-i];
      else if (rep)
        o[CH_OUT_W-1-i] = v[2*w-1-i];
    end
    return o;
  endfunction

  // Handshake / advance control
  logic v1, v2;
  logic adv1, adv2;
  logic in_xfer;

  assign adv2    = !v2 || m_ready;
  assign adv1    = !v1 || adv2;
  assign s_ready = adv1;
  assign in_xfer = s_valid && s_ready;
  assign m_valid = v2;

  // Channel unpacking, right-aligned into CH_OUT_W bits for the expander
  logic [R_IN_W-1:0]   r_in;
  logic [G_IN_W-1:0]   g_in;
  logic [B_IN_W-1:0]   b_in;
  logic [CH_OUT_W-1:0] r_ext, g_ext, b_ext;
  logic                rep_sel;
  logic [CH_OUT_W-1:0] r_exp, g_exp, b_exp;

  assign r_in  = s_data[IN_W-1 -: R_IN_W];
  assign g_in  = s_data[B_IN_W +: G_IN_W];
  assign b_in  = s_data[B_IN_W-1:0];
  assign r_ext = CH_OUT_W'(r_in);
  assign g_ext = CH_OUT_W'(g_in);
  assign b_ext = CH_OUT_W'(b_in);

  // Greyscale is computed on replicated values, so only mode 00 zero-pads
  assign rep_sel = (mode != MODE_ZERO);
  assign r_exp   = expand(r_ext, R_IN_W, rep_sel);
  assign g_exp   = expand(g_ext, G_IN_W, rep_sel);
  assign b_exp   = expand(b_ext, B_IN_W, rep_sel);

  // Stage 1: expanded channels plus sideband and mode
  logic [CH_OUT_W-1:0] r1, g1, b1;
  logic                sof1, eol1;
  logic [1:0]          mode1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      r1    <= '0;
      g1    <= '0;
      b1    <= '0;
      sof1  <= 1'b0;
      eol1  <= 1'b0;
      mode1 <= 2'b00;
    end else if (adv1) begin
      v1 <= s_valid;
      if (s_valid) begin
        r1    <= r_exp;
        g1    <= g_exp;
        b1    <= b_exp;
        sof1  <= s_sof;
        eol1  <= s_eol;
        mode1 <= mode;
      end
    end
  end

  // Stage 2 combinational: luma (R + 2G + B) / 4, truncated
  logic [CH_OUT_W+1:0] y_sum;
  logic [CH_OUT_W-1:0] y_val;
  logic [3*CH_OUT_W-1:0] s2_data;

  assign y_sum = {2'b00, r1} + {1'b0, g1, 1'b0} + {2'b00, b1};
  assign y_val = y_sum[CH_OUT_W+1:2];

  always_comb begin
    s2_data = {r1, g1, b1};
    if (mode1 == MODE_GREY)
      s2_data = {y_val, y_val, y_val};
  end

  // Stage 2 register: holds m_data/m_sof/m_eol stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      m_data <= '0;
      m_sof  <= 1'b0;
      m_eol  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        m_data <= s2_data;
        m_sof  <= sof1;
        m_eol  <= eol1;
      end
    end
  end

`ifdef PIXEL_FMT_CONV_STATS_EN
  // A start-of-frame beat is the first pixel of its frame, hence the load of 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= 32'd0;
      frame_cnt <= 16'd0;
    end else if (m_valid && m_ready) begin
      if (m_sof) begin
        pix_cnt   <= 32'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        pix_cnt <= pix_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_fmt_conv.sv
// tb/tb_pixel_fmt_conv.sv - self-checking bench for pixel_fmt_conv with scoreboard model
module tb_pixel_fmt_conv;

  localparam int RW = 5;
  localparam int GW = 6;
  localparam int BW = 5;
  localparam int CO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;
`ifdef PIXEL_FMT_CONV_STATS_EN
  logic [31:0] pix_cnt;
  logic [15:0] frame_cnt;
`endif

  pixel_fmt_conv #(.R_IN_W(RW), .G_IN_W(GW), .B_IN_W(BW), .CH_OUT_W(CO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof),
`ifdef PIXEL_FMT_CONV_STATS_EN
    .m_eol(m_eol), .pix_cnt(pix_cnt), .frame_cnt(frame_cnt)
`else
    .m_eol(m_eol)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [25:0] q[$];
  int n_out = 0;
  int sof_seen = 0;
  int eol_seen = 0;
  logic acc_last = 1'b0;
  logic prev_stall = 1'b0;
  logic [25:0] prev_word = '0;
  logic obs_mv;
  logic [23:0] obs_md;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: channel value v of width w scaled into CO bits
  function automatic int ch8(input int v, input int w, input bit rep);
    int z;
    z = (v << (CO - w)) & ((1 << CO) - 1);
    if (rep) z = z | (v >> (2 * w - CO));
    return z;
  endfunction

  function automatic logic [25:0] ref_pix(input logic [15:0] d, input logic [1:0] md,
                                          input logic sof, input logic eol);
    int r, g, b, r8, g8, b8, y;
    bit rep;
    r = (int'(d) >> (GW + BW)) & ((1 << RW) - 1);
    g = (int'(d) >> BW) & ((1 << GW) - 1);
    b = int'(d) & ((1 << BW) - 1);
    rep = (md != 2'b00);
    r8 = ch8(r, RW, rep);
    g8 = ch8(g, GW, rep);
    b8 = ch8(b, BW, rep);
    if (md == 2'b10) begin
      y = (r8 + 2 * g8 + b8) / 4;
      r8 = y; g8 = y; b8 = y;
    end
    return {sof, eol, 8'(r8), 8'(g8), 8'(b8)};
  endfunction

  // One clock: drive at negedge, observe/score just after, transfer at posedge
  task automatic cycle(input logic sv, input logic [15:0] d, input logic sof,
                       input logic eol, input logic [1:0] md, input logic mr);
    @(negedge clk);
    s_valid = sv; s_data = d; s_sof = sof; s_eol = eol; mode = md; m_ready = mr;
    #1;
    obs_mv = m_valid;
    obs_md = m_data;
    if (prev_stall) begin
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_word", 64'({m_sof, m_eol, m_data}), 64'(prev_word));
    end
    chk("s_ready", 64'(s_ready), 64'(!(q.size() == 2 && !mr)));
    if (m_valid && mr) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(q.size()), 64'd1);
      end else begin
        chk("out_word", 64'({m_sof, m_eol, m_data}), 64'(q[0]));
        void'(q.pop_front());
      end
      n_out++;
      if (m_sof) sof_seen++;
      if (m_eol) eol_seen++;
    end
    acc_last = sv && s_ready;
    if (acc_last) q.push_back(ref_pix(d, md, sof, eol));
    prev_stall = m_valid && !mr;
    prev_word = {m_sof, m_eol, m_data};
    @(posedge clk);
  endtask

  task automatic single(input logic [15:0] d, input logic [1:0] md, input logic [23:0] exp,
                        input string tag);
    cycle(1'b1, d, 1'b0, 1'b0, md, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk({tag, "_lat1"}, 64'(obs_mv), 64'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk({tag, "_lat2"}, 64'(obs_mv), 64'd1);
    chk({tag, "_data"}, 64'(obs_md), 64'(exp));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int sent;
    int guard;
    logic [15:0] base;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_sof", 64'({m_sof, m_eol}), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // Directed expansion and greyscale cases
    single(16'hFFFF, 2'b00, 24'hF8FCF8, "ffff_zero");
    single(16'hFFFF, 2'b01, 24'hFFFFFF, "ffff_rep");
    single(16'h8410, 2'b01, 24'h848284, "8410_rep");
    single(16'h8410, 2'b00, 24'h808080, "8410_zero");
    single(16'h8410, 2'b11, 24'h848284, "8410_m11");
    single(16'hF800, 2'b10, 24'h3F3F3F, "grey_red");
    single(16'h07E0, 2'b10, 24'h7F7F7F, "grey_green");

    // Back-pressure: 10 incrementing pixels, random m_ready
    n_out = 0;
    sent = 0;
    base = 16'($urandom);
    guard = 0;
    while ((sent < 10 || q.size() != 0) && guard < 400) begin
      cycle(sent < 10, base + 16'(sent), 1'b0, 1'b0, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      if (acc_last) sent++;
      guard++;
    end
    chk("bp_guard", 64'(guard < 400), 64'd1);
    chk("bp_count", 64'(n_out), 64'd10);

    // Sideband: sof on pixel 0, eol on pixel 3
    sof_seen = 0;
    eol_seen = 0;
    sent = 0;
    guard = 0;
    while (sent < 5 && guard < 100) begin
      cycle(1'b1, 16'($urandom), sent == 0, sent == 3, 2'b01, 1'($urandom_range(0, 1)));
      if (acc_last) sent++;
      guard++;
    end
    drain();
    chk("sof_count", 64'(sof_seen), 64'd1);
    chk("eol_count", 64'(eol_seen), 64'd1);

    // Random stress with mixed modes and sideband
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset with two pixels in flight
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 2'b00, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("full_m_valid", 64'(m_valid), 64'd1);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
      chk("post_rst_quiet", 64'(obs_mv), 64'd0);
    end

`ifdef PIXEL_FMT_CONV_STATS_EN
    // Two frames of 4 pixels
    sent = 0;
    guard = 0;
    while (sent < 8 && guard < 100) begin
      cycle(1'b1, 16'($urandom), (sent % 4) == 0, (sent % 4) == 3, 2'b00, 1'b1);
      if (acc_last) sent++;
      guard++;
    end
    drain();
    chk("pix_cnt", 64'(pix_cnt), 64'd4);
    chk("frame_cnt", 64'(frame_cnt), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
